// File: rtl/awb_corr_multimode.sv
// Auto-white-balance statistics collector and R/B gain calculator.
// The module only taps the RGB pixel stream, so tready is always 1.
// It gathers per-frame max-RGB or gray-world statistics. On each start of
// frame a single restoring divider computes G/R and G/B gains in sequence.
// The gains are fixed-point values with FRACT_WIDTH fractional bits.
// tlast carries no information for this block, so it is not brought in.
module awb_corr_multimode #(
  parameter int PX_WIDTH    = 10,
  parameter int FRACT_WIDTH = 10,
  parameter int COEF_WIDTH  = PX_WIDTH + FRACT_WIDTH,
  parameter int SUM_WIDTH   = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    video_tvalid_i,
  input  logic [3*PX_WIDTH-1:0]   video_tdata_i,
  input  logic                    video_tuser_i,
  output logic                    video_tready_o,
  input  logic                    mode_i,
  input  logic [PX_WIDTH-1:0]     sat_thresh_i,
  output logic [COEF_WIDTH-1:0]   r_corr_o,
  output logic [COEF_WIDTH-1:0]   b_corr_o,
  output logic                    corr_valid_o,
  output logic                    busy_o
);

  localparam int DIV_W = SUM_WIDTH + FRACT_WIDTH;
  localparam int CNT_W = $clog2(DIV_W);
  localparam logic [COEF_WIDTH-1:0] FIXED_ONE = {{(COEF_WIDTH-1){1'b0}}, 1'b1} << FRACT_WIDTH;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_W - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_DIV_R, ST_DIV_B, ST_UPDATE} state_t;

  // Channel index order used by the statistics arrays: 0 = R, 1 = G, 2 = B.
  logic [PX_WIDTH-1:0]  px_s    [3];
  logic [PX_WIDTH-1:0]  max_r   [3];
  logic [SUM_WIDTH-1:0] sum_r   [3];
  logic                 stats_valid_r;
  logic                 beat_s;
  logic                 incl_s;
  logic                 snap_s;

  state_t               state_r;
  state_t               state_s;
  logic [CNT_W-1:0]     cnt_r;
  logic                 last_s;

  logic [SUM_WIDTH-1:0] op_r_r;
  logic [SUM_WIDTH-1:0] op_g_r;
  logic [SUM_WIDTH-1:0] op_b_r;
  logic [SUM_WIDTH-1:0] snap_r_s;
  logic [SUM_WIDTH-1:0] snap_g_s;
  logic [SUM_WIDTH-1:0] snap_b_s;

  logic [DIV_W-1:0]     dq_r;
  logic [SUM_WIDTH-1:0] rem_r;
  logic [SUM_WIDTH-1:0] divisor_s;
  logic [SUM_WIDTH:0]   trial_s;
  logic [SUM_WIDTH-1:0] rem_s;
  logic                 qbit_s;
  logic [DIV_W-1:0]     dq_s;
  logic [COEF_WIDTH-1:0] r_gain_r;
  logic [COEF_WIDTH-1:0] b_gain_r;

  // Adds a pixel component to a channel sum and clamps at all-ones instead of wrapping.
  function automatic logic [SUM_WIDTH-1:0] sat_add(input logic [SUM_WIDTH-1:0] acc,
                                                   input logic [PX_WIDTH-1:0]  px);
    logic [SUM_WIDTH:0] t;
    t = {1'b0, acc} + (SUM_WIDTH+1)'(px);
    if (t[SUM_WIDTH]) begin
      sat_add = {SUM_WIDTH{1'b1}};
    end else begin
      sat_add = t[SUM_WIDTH-1:0];
    end
  endfunction

  // Turns a raw quotient into a gain: a zero divisor gives unity, and overflow clamps to all-ones.
  function automatic logic [COEF_WIDTH-1:0] gain_f(input logic [DIV_W-1:0]     q,
                                                   input logic [SUM_WIDTH-1:0] d);
    if (d == {SUM_WIDTH{1'b0}}) begin
      gain_f = FIXED_ONE;
    end else if (|q[DIV_W-1:COEF_WIDTH]) begin
      gain_f = {COEF_WIDTH{1'b1}};
    end else begin
      gain_f = q[COEF_WIDTH-1:0];
    end
  endfunction

  assign video_tready_o = 1'b1;

  // Splits the beat into components, decides inclusion and detects a snapshot.
  always_comb begin
    px_s[0] = video_tdata_i[3*PX_WIDTH-1:2*PX_WIDTH];
    px_s[1] = video_tdata_i[PX_WIDTH-1:0];
    px_s[2] = video_tdata_i[2*PX_WIDTH-1:PX_WIDTH];
    beat_s  = video_tvalid_i;
    incl_s  = (px_s[0] < sat_thresh_i) && (px_s[1] < sat_thresh_i) && (px_s[2] < sat_thresh_i);
    snap_s  = beat_s && video_tuser_i && (state_r == ST_IDLE) && stats_valid_r;
    if (mode_i) begin
      snap_r_s = sum_r[0];
      snap_g_s = sum_r[1];
      snap_b_s = sum_r[2];
    end else begin
      snap_r_s = SUM_WIDTH'(max_r[0]);
      snap_g_s = SUM_WIDTH'(max_r[1]);
      snap_b_s = SUM_WIDTH'(max_r[2]);
    end
  end

  // Per-frame statistics: a tuser beat restarts them from its own pixel.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stats_valid_r <= 1'b0;
      for (int c = 0; c < 3; c++) begin
        max_r[c] <= {PX_WIDTH{1'b0}};
        sum_r[c] <= {SUM_WIDTH{1'b0}};
      end
    end else if (beat_s) begin
      stats_valid_r <= 1'b1;
      for (int c = 0; c < 3; c++) begin
        if (video_tuser_i) begin
          max_r[c] <= incl_s ? px_s[c] : {PX_WIDTH{1'b0}};
          sum_r[c] <= incl_s ? SUM_WIDTH'(px_s[c]) : {SUM_WIDTH{1'b0}};
        end else if (incl_s) begin
          max_r[c] <= (px_s[c] > max_r[c]) ? px_s[c] : max_r[c];
          sum_r[c] <= sat_add(sum_r[c], px_s[c]);
        end
      end
    end
  end

  // One restoring-division step on the quotient/dividend shift register.
  always_comb begin
    divisor_s = (state_r == ST_DIV_B) ? op_b_r : op_r_r;
    trial_s   = {rem_r, dq_r[DIV_W-1]};
    if (trial_s >= {1'b0, divisor_s}) begin
      rem_s  = trial_s[SUM_WIDTH-1:0] - divisor_s;
      qbit_s = 1'b1;
    end else begin
      rem_s  = trial_s[SUM_WIDTH-1:0];
      qbit_s = 1'b0;
    end
    dq_s   = {dq_r[DIV_W-2:0], qbit_s};
    last_s = (cnt_r == CNT_LAST);
  end

  // Next-state logic for the divider sequencer.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE:   state_s = snap_s ? ST_DIV_R : ST_IDLE;
      ST_DIV_R:  state_s = last_s ? ST_DIV_B : ST_DIV_R;
      ST_DIV_B:  state_s = last_s ? ST_UPDATE : ST_DIV_B;
      ST_UPDATE: state_s = ST_IDLE;
      default:   state_s = ST_IDLE;
    endcase
  end

  // Sequencer state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Operand capture and divider datapath; the R gain is kept until B is done.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      op_r_r   <= {SUM_WIDTH{1'b0}};
      op_g_r   <= {SUM_WIDTH{1'b0}};
      op_b_r   <= {SUM_WIDTH{1'b0}};
      dq_r     <= {DIV_W{1'b0}};
      rem_r    <= {SUM_WIDTH{1'b0}};
      cnt_r    <= {CNT_W{1'b0}};
      r_gain_r <= FIXED_ONE;
      b_gain_r <= FIXED_ONE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (snap_s) begin
            op_r_r <= snap_r_s;
            op_g_r <= snap_g_s;
            op_b_r <= snap_b_s;
            dq_r   <= {snap_g_s, {FRACT_WIDTH{1'b0}}};
            rem_r  <= {SUM_WIDTH{1'b0}};
            cnt_r  <= {CNT_W{1'b0}};
          end
        end
        ST_DIV_R: begin
          if (last_s) begin
            r_gain_r <= gain_f(dq_s, op_r_r);
            dq_r     <= {op_g_r, {FRACT_WIDTH{1'b0}}};
            rem_r    <= {SUM_WIDTH{1'b0}};
            cnt_r    <= {CNT_W{1'b0}};
          end else begin
            dq_r  <= dq_s;
            rem_r <= rem_s;
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        ST_DIV_B: begin
          if (last_s) begin
            b_gain_r <= gain_f(dq_s, op_b_r);
            cnt_r    <= {CNT_W{1'b0}};
          end else begin
            dq_r  <= dq_s;
            rem_r <= rem_s;
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        ST_UPDATE: begin
          cnt_r <= {CNT_W{1'b0}};
        end
        default: begin
          cnt_r <= {CNT_W{1'b0}};
        end
      endcase
    end
  end

  // Registered outputs: both gains load together with a one-cycle valid pulse.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_corr_o     <= FIXED_ONE;
      b_corr_o     <= FIXED_ONE;
      corr_valid_o <= 1'b0;
      busy_o       <= 1'b0;
    end else begin
      busy_o <= (state_s != ST_IDLE);
      if (state_r == ST_UPDATE) begin
        r_corr_o     <= r_gain_r;
        b_corr_o     <= b_gain_r;
        corr_valid_o <= 1'b1;
      end else begin
        corr_valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_awb_corr_multimode.sv
// Self-checking bench for awb_corr_multimode. A behavioural model predicts a
// gain pair for every frame close that should start a calculation and queues
// the pair. The test that drove the frame pops it when corr_valid_o pulses.
module tb_awb_corr_multimode;

  localparam int PXW   = 10;
  localparam int FW    = 10;
  localparam int CW    = PXW + FW;
  localparam int SW    = 32;
  localparam int DIV_W = SW + FW;
  localparam int ONE   = 1024;
  // The pulse is sampled by the (2*DIV_W+2)th edge after the tuser edge.
  // Sampled on the falling edge, it is seen (2*DIV_W+1) edges after the tuser edge.
  localparam int LAT_SEEN = 2 * DIV_W + 1;

  logic            clk_i = 1'b0;
  logic            rst_i = 1'b1;
  logic            tvalid = 1'b0;
  logic [3*PXW-1:0] tdata = '0;
  logic            tuser = 1'b0;
  logic            tready;
  logic            mode = 1'b0;
  logic [PXW-1:0]  thresh = 10'd1023;
  logic [CW-1:0]   r_corr;
  logic [CW-1:0]   b_corr;
  logic            corr_valid;
  logic            busy;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // model state
  int      m_max [3];
  longint  m_sum [3];
  bit      m_valid = 1'b0;
  int      m_idle_at = 0;
  int      snap_cyc = 0;
  longint  exp_r_q [$];
  longint  exp_b_q [$];

  awb_corr_multimode dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .video_tvalid_i (tvalid),
    .video_tdata_i  (tdata),
    .video_tuser_i  (tuser),
    .video_tready_o (tready),
    .mode_i         (mode),
    .sat_thresh_i   (thresh),
    .r_corr_o       (r_corr),
    .b_corr_o       (b_corr),
    .corr_valid_o   (corr_valid),
    .busy_o         (busy)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  function automatic longint exp_gain(longint num, longint den);
    longint q;
    if (den == 0) return ONE;
    q = (num << FW) / den;
    if (q > 1048575) return 1048575;
    return q;
  endfunction

  task automatic model_clear();
    m_valid = 1'b0;
    m_idle_at = 0;
    for (int c = 0; c < 3; c++) begin m_max[c] = 0; m_sum[c] = 0; end
    exp_r_q.delete();
    exp_b_q.delete();
  endtask

  // Drives one beat and updates the model with the spec's statistics rules.
  task automatic send_pixel(input int r, input int g, input int b, input bit tu);
    int  px [3];
    bit  incl;
    logic [PXW-1:0] rv, gv, bv;
    rv = r[PXW-1:0]; gv = g[PXW-1:0]; bv = b[PXW-1:0];
    tdata = {rv, bv, gv};
    tuser = tu;
    tvalid = 1'b1;
    @(posedge clk_i);
    #1;
    tvalid = 1'b0;
    tuser = 1'b0;
    px[0] = r; px[1] = g; px[2] = b;
    incl = (r < int'(thresh)) && (g < int'(thresh)) && (b < int'(thresh));
    if (tu) begin
      if (m_valid && cyc >= m_idle_at) begin
        if (mode) begin
          exp_r_q.push_back(exp_gain(m_sum[1], m_sum[0]));
          exp_b_q.push_back(exp_gain(m_sum[1], m_sum[2]));
        end else begin
          exp_r_q.push_back(exp_gain(m_max[1], m_max[0]));
          exp_b_q.push_back(exp_gain(m_max[1], m_max[2]));
        end
        m_idle_at = cyc + 2 * DIV_W + 2;
        snap_cyc = cyc;
      end
      for (int c = 0; c < 3; c++) begin
        m_max[c] = incl ? px[c] : 0;
        m_sum[c] = incl ? px[c] : 0;
      end
    end else if (incl) begin
      for (int c = 0; c < 3; c++) begin
        if (px[c] > m_max[c]) m_max[c] = px[c];
        m_sum[c] = m_sum[c] + px[c];
      end
    end
    m_valid = 1'b1;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    model_clear();
  endtask

  // Watches a fixed window, counting pulses and the first pulse latency.
  task automatic watch(input int window, output int lat, output int npulse);
    lat = -1;
    npulse = 0;
    repeat (window) begin
      @(negedge clk_i);
      if (corr_valid === 1'b1) begin
        npulse++;
        if (lat < 0) lat = cyc - snap_cyc;
      end
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    checks++; if (r_corr !== CW'(ONE)) begin errors++; $display("FAIL reset_r: got %0d expected %0d", r_corr, ONE); end
    checks++; if (b_corr !== CW'(ONE)) begin errors++; $display("FAIL reset_b: got %0d expected %0d", b_corr, ONE); end
    checks++; if (corr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b expected 0", corr_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b expected 0", busy); end
    checks++; if (tready !== 1'b1) begin errors++; $display("FAIL tready: got %0b expected 1", tready); end
    #1;
    rst_i = 1'b0;
    model_clear();
  endtask

  task automatic test_first_frame();
    int lat, np;
    do_reset();
    mode = 1'b0; thresh = 10'd1023;
    send_pixel(100, 200, 300, 1'b1);
    send_pixel(50, 60, 70, 1'b0);
    watch(100, lat, np);
    checks++; if (np != 0) begin errors++; $display("FAIL first_frame_pulse: got %0d pulses expected 0", np); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL first_frame_busy: got %0b expected 0", busy); end
  endtask

  task automatic test_max_mode();
    int lat, np;
    longint er, eb;
    do_reset();
    mode = 1'b0; thresh = 10'd1023;
    send_pixel(256, 100, 50, 1'b1);
    send_pixel(10, 512, 300, 1'b0);
    send_pixel(100, 20, 1022, 1'b0);
    send_pixel(5, 5, 5, 1'b0);
    send_pixel(7, 7, 7, 1'b1);
    @(negedge clk_i);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL max_busy: got %0b expected 1", busy); end
    watch(120, lat, np);
    checks++; if (np != 1) begin errors++; $display("FAIL max_pulses: got %0d expected 1", np); end
    checks++; if (lat != LAT_SEEN) begin errors++; $display("FAIL max_latency: got %0d expected %0d", lat, LAT_SEEN); end
    er = (exp_r_q.size() > 0) ? exp_r_q.pop_front() : -1;
    eb = (exp_b_q.size() > 0) ? exp_b_q.pop_front() : -1;
    checks++; if (longint'(r_corr) != er) begin errors++; $display("FAIL max_r_model: got %0d expected %0d", r_corr, er); end
    checks++; if (longint'(b_corr) != eb) begin errors++; $display("FAIL max_b_model: got %0d expected %0d", b_corr, eb); end
    checks++; if (r_corr !== CW'(2048)) begin errors++; $display("FAIL max_r: got %0d expected 2048", r_corr); end
    checks++; if (b_corr !== CW'(513)) begin errors++; $display("FAIL max_b: got %0d expected 513", b_corr); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL max_busy_end: got %0b expected 0", busy); end
  endtask

  task automatic test_gray_world();
    int lat, np;
    longint er, eb;
    do_reset();
    mode = 1'b1; thresh = 10'd1023;
    send_pixel(100, 200, 400, 1'b1);
    repeat (3) send_pixel(100, 200, 400, 1'b0);
    send_pixel(900, 900, 900, 1'b1);
    // inputs changing mid-calculation must not disturb the latched operands
    mode = 1'b0; thresh = 10'd5;
    watch(120, lat, np);
    checks++; if (np != 1) begin errors++; $display("FAIL gray_pulses: got %0d expected 1", np); end
    er = (exp_r_q.size() > 0) ? exp_r_q.pop_front() : -1;
    eb = (exp_b_q.size() > 0) ? exp_b_q.pop_front() : -1;
    checks++; if (longint'(r_corr) != er) begin errors++; $display("FAIL gray_r_model: got %0d expected %0d", r_corr, er); end
    checks++; if (longint'(b_corr) != eb) begin errors++; $display("FAIL gray_b_model: got %0d expected %0d", b_corr, eb); end
    checks++; if (r_corr !== CW'(2048)) begin errors++; $display("FAIL gray_r: got %0d expected 2048", r_corr); end
    checks++; if (b_corr !== CW'(512)) begin errors++; $display("FAIL gray_b: got %0d expected 512", b_corr); end
    repeat (5) @(negedge clk_i);
    checks++; if (r_corr !== CW'(2048)) begin errors++; $display("FAIL gray_hold: got %0d expected 2048", r_corr); end
  endtask

  task automatic test_saturation_exclusion();
    int lat, np;
    longint er, eb;
    do_reset();
    mode = 1'b0; thresh = 10'd1000;
    send_pixel(1020, 500, 500, 1'b1);
    send_pixel(250, 500, 250, 1'b0);
    send_pixel(1, 1, 1, 1'b1);
    watch(120, lat, np);
    checks++; if (np != 1) begin errors++; $display("FAIL excl_pulses: got %0d expected 1", np); end
    er = (exp_r_q.size() > 0) ? exp_r_q.pop_front() : -1;
    eb = (exp_b_q.size() > 0) ? exp_b_q.pop_front() : -1;
    checks++; if (longint'(r_corr) != er) begin errors++; $display("FAIL excl_r_model: got %0d expected %0d", r_corr, er); end
    checks++; if (longint'(b_corr) != eb) begin errors++; $display("FAIL excl_b_model: got %0d expected %0d", b_corr, eb); end
    checks++; if (r_corr !== CW'(2048)) begin errors++; $display("FAIL excl_r: got %0d expected 2048", r_corr); end
    checks++; if (b_corr !== CW'(2048)) begin errors++; $display("FAIL excl_b: got %0d expected 2048", b_corr); end
  endtask

  task automatic test_zero_divisor();
    int lat, np;
    longint er, eb;
    do_reset();
    mode = 1'b0; thresh = 10'd1023;
    send_pixel(0, 300, 600, 1'b1);
    send_pixel(0, 300, 600, 1'b0);
    send_pixel(3, 3, 3, 1'b1);
    watch(120, lat, np);
    checks++; if (np != 1) begin errors++; $display("FAIL zero_pulses: got %0d expected 1", np); end
    er = (exp_r_q.size() > 0) ? exp_r_q.pop_front() : -1;
    eb = (exp_b_q.size() > 0) ? exp_b_q.pop_front() : -1;
    checks++; if (longint'(r_corr) != er) begin errors++; $display("FAIL zero_r_model: got %0d expected %0d", r_corr, er); end
    checks++; if (longint'(b_corr) != eb) begin errors++; $display("FAIL zero_b_model: got %0d expected %0d", b_corr, eb); end
    checks++; if (r_corr !== CW'(1024)) begin errors++; $display("FAIL zero_r: got %0d expected 1024", r_corr); end
    checks++; if (b_corr !== CW'(512)) begin errors++; $display("FAIL zero_b: got %0d expected 512", b_corr); end
  endtask

  task automatic test_overflow();
    int lat, np;
    longint er, eb;
    do_reset();
    mode = 1'b1; thresh = 10'd1023;
    send_pixel(1, 1022, 1022, 1'b1);
    send_pixel(0, 1022, 1022, 1'b0);
    send_pixel(2, 2, 2, 1'b1);
    watch(120, lat, np);
    checks++; if (np != 1) begin errors++; $display("FAIL ovf_pulses: got %0d expected 1", np); end
    er = (exp_r_q.size() > 0) ? exp_r_q.pop_front() : -1;
    eb = (exp_b_q.size() > 0) ? exp_b_q.pop_front() : -1;
    checks++; if (longint'(r_corr) != er) begin errors++; $display("FAIL ovf_r_model: got %0d expected %0d", r_corr, er); end
    checks++; if (longint'(b_corr) != eb) begin errors++; $display("FAIL ovf_b_model: got %0d expected %0d", b_corr, eb); end
    checks++; if (r_corr !== CW'(1048575)) begin errors++; $display("FAIL ovf_r: got %0d expected 1048575", r_corr); end
    checks++; if (b_corr !== CW'(1024)) begin errors++; $display("FAIL ovf_b: got %0d expected 1024", b_corr); end
  endtask

  task automatic test_back_to_back();
    int lat, np;
    longint er, eb;
    do_reset();
    mode = 1'b0; thresh = 10'd1023;
    send_pixel(200, 400, 100, 1'b1);
    send_pixel(100, 100, 100, 1'b0);
    send_pixel(9, 9, 9, 1'b1);
    repeat (9) @(posedge clk_i);
    #1;
    send_pixel(300, 300, 300, 1'b1);
    watch(160, lat, np);
    checks++; if (np != 1) begin errors++; $display("FAIL b2b_pulses: got %0d expected 1", np); end
    checks++; if (lat != LAT_SEEN) begin errors++; $display("FAIL b2b_latency: got %0d expected %0d", lat, LAT_SEEN); end
    er = (exp_r_q.size() > 0) ? exp_r_q.pop_front() : -1;
    eb = (exp_b_q.size() > 0) ? exp_b_q.pop_front() : -1;
    checks++; if (longint'(r_corr) != er) begin errors++; $display("FAIL b2b_r_model: got %0d expected %0d", r_corr, er); end
    checks++; if (longint'(b_corr) != eb) begin errors++; $display("FAIL b2b_b_model: got %0d expected %0d", b_corr, eb); end
    checks++; if (exp_r_q.size() != 0) begin errors++; $display("FAIL b2b_extra_snap: got %0d pending expected 0", exp_r_q.size()); end
  endtask

  // Runs without a leading reset so the outputs hold non-unity gains from the previous frame.
  task automatic test_reset_mid_calc();
    int lat, np;
    send_pixel(500, 500, 500, 1'b1);
    repeat (39) @(posedge clk_i);
    @(negedge clk_i);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midrst_busy_before: got %0b expected 1", busy); end
    checks++; if (r_corr === CW'(ONE)) begin errors++; $display("FAIL midrst_pre_r: got %0d expected not %0d", r_corr, ONE); end
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    model_clear();
    @(negedge clk_i);
    checks++; if (r_corr !== CW'(ONE)) begin errors++; $display("FAIL midrst_r: got %0d expected %0d", r_corr, ONE); end
    checks++; if (b_corr !== CW'(ONE)) begin errors++; $display("FAIL midrst_b: got %0d expected %0d", b_corr, ONE); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %0b expected 0", busy); end
    watch(120, lat, np);
    checks++; if (np != 0) begin errors++; $display("FAIL midrst_pulse: got %0d pulses expected 0", np); end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_first_frame();
    test_max_mode();
    test_gray_world();
    test_saturation_exclusion();
    test_zero_divisor();
    test_overflow();
    test_back_to_back();
    test_reset_mid_calc();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
